// File: rtl/rrat_retire_pkg.sv
// Shared types for the retirement RAT slice.
// Defines the retire input packet, the committed map entry (also used by the
// speculative RAT's rollback load port), and the freed-tag output packet.
// `PREG_IDX_WIDTH sets the physical tag width and may be overridden on the
// command line.
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 7
`endif

package rrat_retire_pkg;
  localparam int RRAT_NUM_ENTRIES = 64;
  localparam int RRAT_SCALAR      = 2;
  localparam int ARCH_IDX_W       = $clog2(RRAT_NUM_ENTRIES);
  localparam int PREG_W           = `PREG_IDX_WIDTH;

  typedef struct packed {
    logic                        valid;
    logic [ARCH_IDX_W-1:0]       arch_addr;
    logic [`PREG_IDX_WIDTH-1:0]  tag;
  } RRAT_RETIRE_INPACKET;

  typedef struct packed {
    logic [`PREG_IDX_WIDTH-1:0]  rrat_tag;
  } RRAT_ENTRY;

  typedef struct packed {
    logic                        valid;
    logic [`PREG_IDX_WIDTH-1:0]  tag;
  } RRAT_FREE_OUTPACKET;

  // A retire only touches the map when it is valid and not aimed at x0,
  // which is never renamed.
  function automatic logic retire_live(input RRAT_RETIRE_INPACKET p);
    return p.valid && (p.arch_addr != '0);
  endfunction
endpackage

// File: rtl/rrat_free_calc.sv
// Combinational superseded-tag calculation for the two retire slots.
// Ports:
//   ret_i      - the two retire packets (slot 0 older)
//   old_tag_i  - committed tag currently held at each slot's arch_addr
//   free_o     - tag each slot releases to the free list (valid=0, tag=0 if none)
module rrat_free_calc
  import rrat_retire_pkg::*;
(
  input  RRAT_RETIRE_INPACKET [1:0]             ret_i,
  input  logic                [1:0][PREG_W-1:0] old_tag_i,
  output RRAT_FREE_OUTPACKET  [1:0]             free_o
);
  logic live0, live1, same_addr;

  assign live0     = retire_live(ret_i[0]);
  assign live1     = retire_live(ret_i[1]);
  // Slot 1 chained behind slot 0 on the same register supersedes slot 0's tag,
  // not the stale committed one. live1 already excludes x0.
  assign same_addr = live0 && (ret_i[0].arch_addr == ret_i[1].arch_addr);

  always_comb begin
    free_o = '0;
    if (live0) begin
      free_o[0].valid = 1'b1;
      free_o[0].tag   = old_tag_i[0];
    end
    if (live1) begin
      free_o[1].valid = 1'b1;
      free_o[1].tag   = same_addr ? ret_i[0].tag : old_tag_i[1];
    end
  end
endmodule

// File: rtl/rrat_retire.sv
// Retirement register alias table: committed arch->phys map.
// Up to two instructions retire per cycle; each overwrites its committed
// mapping and releases the superseded physical tag one cycle later.
// Ports:
//   clock            - rising-edge clock
//   reset            - asynchronous active-low reset
//   retire_packet    - two retire slots {valid, arch_addr, tag}, slot 0 older
//   rollback         - mispredict flush marker; no effect on state here
//   rrat_copy_packet - full committed map, loaded by the RAT on rollback
//   freed_packet     - registered tags returned to the free list
// Build option: RRAT_BYPASS_EN merges this cycle's retires into
// rrat_copy_packet combinationally; otherwise the copy is purely registered.
module rrat_retire
  import rrat_retire_pkg::*;
#(
  parameter int NUM_ENTRIES = RRAT_NUM_ENTRIES,
  parameter int SCALAR      = RRAT_SCALAR
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  RRAT_RETIRE_INPACKET [SCALAR-1:0]      retire_packet,
  input  logic                                  rollback,
  output RRAT_ENTRY           [NUM_ENTRIES-1:0] rrat_copy_packet,
  output RRAT_FREE_OUTPACKET  [SCALAR-1:0]      freed_packet
);
  RRAT_ENTRY          [NUM_ENTRIES-1:0] rrat_q, rrat_d;
  RRAT_FREE_OUTPACKET [1:0]             free_d, free_q;
  logic               [1:0][PREG_W-1:0] old_tag;
  logic                                 rollback_unused;

  // Retires in the rollback cycle still commit, so rollback is not consumed.
  assign rollback_unused = rollback;

  assign old_tag[0] = rrat_q[retire_packet[0].arch_addr].rrat_tag;
  assign old_tag[1] = rrat_q[retire_packet[1].arch_addr].rrat_tag;

  rrat_free_calc u_free_calc (
    .ret_i     (retire_packet),
    .old_tag_i (old_tag),
    .free_o    (free_d)
  );

  // Next map: slot 1 is applied after slot 0 so it wins on a shared address.
  always_comb begin
    rrat_d = rrat_q;
    for (int d = 0; d < NUM_ENTRIES; d++) begin
      if (retire_live(retire_packet[0]) &&
          retire_packet[0].arch_addr == ARCH_IDX_W'(d))
        rrat_d[d].rrat_tag = retire_packet[0].tag;
      if (retire_live(retire_packet[1]) &&
          retire_packet[1].arch_addr == ARCH_IDX_W'(d))
        rrat_d[d].rrat_tag = retire_packet[1].tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Identity map mirrors the speculative RAT's reset state.
      for (int d = 0; d < NUM_ENTRIES; d++)
        rrat_q[d].rrat_tag <= PREG_W'(d);
      free_q <= '0;
    end else begin
      rrat_q <= rrat_d;
      free_q <= free_d;
    end
  end

  assign freed_packet = free_q;

`ifdef RRAT_BYPASS_EN
  // Lets rollback coincide with the retire of the branch and older ops.
  assign rrat_copy_packet = rrat_d;
`else
  assign rrat_copy_packet = rrat_q;
`endif
endmodule

// File: tb/tb_rrat_retire.sv
// Directed bench for rrat_retire with an architectural-level reference model:
// the map is an int array updated slot by slot in program order.
module tb_rrat_retire;
  import rrat_retire_pkg::*;

  logic                          clock = 1'b0;
  logic                          reset = 1'b0;
  logic                          rollback = 1'b0;
  RRAT_RETIRE_INPACKET [1:0]     retire_packet = '0;
  RRAT_ENTRY           [63:0]    copy;
  RRAT_FREE_OUTPACKET  [1:0]     freed;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  rrat_retire dut (
    .clock            (clock),
    .reset            (reset),
    .retire_packet    (retire_packet),
    .rollback         (rollback),
    .rrat_copy_packet (copy),
    .freed_packet     (freed)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int mmap[64];
  int mfv[2];
  int mft[2];
  int nmap[64];
  int nfv[2];
  int nft[2];

  // Effect of the current inputs, applied in program order (slot 0 then 1).
  always_comb begin
    nmap = mmap;
    nfv  = '{0, 0};
    nft  = '{0, 0};
    for (int r = 0; r < 2; r++) begin
      if (retire_packet[r].valid && retire_packet[r].arch_addr != 0) begin
        nfv[r] = 1;
        nft[r] = nmap[retire_packet[r].arch_addr];
        nmap[retire_packet[r].arch_addr] = int'(retire_packet[r].tag);
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mmap[i] <= i;
      mfv <= '{0, 0};
      mft <= '{0, 0};
    end else begin
      mmap <= nmap;
      mfv  <= nfv;
      mft  <= nft;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int bad_idx;
  int bad_exp;
  always @(negedge clock) begin
    if (check_en) begin
      bad_idx = -1;
      bad_exp = 0;
      for (int d = 0; d < 64; d++) begin
`ifdef RRAT_BYPASS_EN
        if (bad_idx < 0 && int'(copy[d].rrat_tag) != nmap[d]) begin
          bad_idx = d; bad_exp = nmap[d];
        end
`else
        if (bad_idx < 0 && int'(copy[d].rrat_tag) != mmap[d]) begin
          bad_idx = d; bad_exp = mmap[d];
        end
`endif
      end
      checks++;
      if (bad_idx >= 0) begin
        failures++;
        $display("FAIL model_copy entry=%0d actual=%0d expected=%0d",
                 bad_idx, copy[bad_idx].rrat_tag, bad_exp);
      end
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("model_freed%0d_valid", r), int'(freed[r].valid), mfv[r]);
        chk($sformatf("model_freed%0d_tag", r),   int'(freed[r].tag),   mft[r]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+2; drives one cycle of retires, returns at next posedge+2
  // with inputs back to idle.
  task automatic ret(input bit v0, input int a0, input int t0,
                     input bit v1, input int a1, input int t1);
    retire_packet[0].valid     = v0;
    retire_packet[0].arch_addr = ARCH_IDX_W'(a0);
    retire_packet[0].tag       = PREG_W'(t0);
    retire_packet[1].valid     = v1;
    retire_packet[1].arch_addr = ARCH_IDX_W'(a1);
    retire_packet[1].tag       = PREG_W'(t1);
    @(posedge clock);
    #2;
    retire_packet = '0;
    rollback      = 1'b0;
  endtask

  int ident_bad;
  initial begin
    repeat (2) @(posedge clock);
    #2;
    reset    = 1'b1;
    check_en = 1'b1;

    // Reset then idle
    repeat (5) @(posedge clock);
    #2;
    ident_bad = 0;
    for (int d = 0; d < 64; d++)
      if (int'(copy[d].rrat_tag) != d) ident_bad++;
    chk("idle_identity_bad_entries", ident_bad, 0);
    chk("idle_freed0_valid", int'(freed[0].valid), 0);
    chk("idle_freed1_valid", int'(freed[1].valid), 0);

    // Single retire slot 0
    ret(1, 5, 40, 0, 0, 0);
    chk("r5_copy5", int'(copy[5].rrat_tag), 40);
    chk("r5_freed0_valid", int'(freed[0].valid), 1);
    chk("r5_freed0_tag", int'(freed[0].tag), 5);
    chk("r5_freed1_valid", int'(freed[1].valid), 0);

    // Same-address chain
    ret(1, 7, 41, 1, 7, 42);
    chk("chain_copy7", int'(copy[7].rrat_tag), 42);
    chk("chain_freed0_tag", int'(freed[0].tag), 7);
    chk("chain_freed1_valid", int'(freed[1].valid), 1);
    chk("chain_freed1_tag", int'(freed[1].tag), 41);

    // x0 suppression on slot 1
    ret(0, 0, 0, 1, 0, 50);
    chk("x0_copy0", int'(copy[0].rrat_tag), 0);
    chk("x0_freed1_valid", int'(freed[1].valid), 0);

    // Slot 1 alone, then two independent addresses
    ret(0, 0, 0, 1, 11, 55);
    chk("s1only_freed0_valid", int'(freed[0].valid), 0);
    chk("s1only_freed1_tag", int'(freed[1].tag), 11);
    ret(1, 12, 20, 1, 13, 21);
    chk("indep_copy12", int'(copy[12].rrat_tag), 20);
    chk("indep_copy13", int'(copy[13].rrat_tag), 21);
    chk("indep_freed1_tag", int'(freed[1].tag), 13);

    // Rewrite of 5 frees the tag installed earlier
    ret(1, 5, 44, 0, 0, 0);
    chk("rewrite_freed0_tag", int'(freed[0].tag), 40);

    // Retire coincident with rollback
    rollback = 1'b1;
    retire_packet[0].valid     = 1'b1;
    retire_packet[0].arch_addr = ARCH_IDX_W'(3);
    retire_packet[0].tag       = PREG_W'(45);
    #1;
`ifdef RRAT_BYPASS_EN
    chk("rb_copy3_same_cycle", int'(copy[3].rrat_tag), 45);
`else
    chk("rb_copy3_same_cycle", int'(copy[3].rrat_tag), 3);
`endif
    @(posedge clock);
    #2;
    retire_packet = '0;
    rollback      = 1'b0;
    chk("rb_copy3_next", int'(copy[3].rrat_tag), 45);
    chk("rb_freed0_tag", int'(freed[0].tag), 3);

    // Async reset mid-cycle
    ret(1, 9, 60, 0, 0, 0);
    chk("pre_rst_copy9", int'(copy[9].rrat_tag), 60);
    reset = 1'b0;
    #1;
    chk("rst_copy9", int'(copy[9].rrat_tag), 9);
    chk("rst_copy5", int'(copy[5].rrat_tag), 5);
    chk("rst_freed0_valid", int'(freed[0].valid), 0);
    chk("rst_freed1_valid", int'(freed[1].valid), 0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Operation after reset
    ret(1, 9, 61, 0, 0, 0);
    chk("post_rst_freed0_tag", int'(freed[0].tag), 9);
    repeat (2) @(posedge clock);
    #2;
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
